// File: rtl/npu_mem_pkg.sv
// Shared types and constants for the NPU memory arbiter slice.
package npu_mem_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_NPU  = 1'b1;

    localparam logic [2:0] MEM_ADDR_DEF = 3'b010;

endpackage

// File: rtl/npu_mem_clr_seq.sv
// Zero-fill sweep counter: walks 0..DEPTH-1 one word per enabled cycle and flags the last word.
module npu_mem_clr_seq #(
    parameter int DEPTH    = 512,
    parameter int REGSEL_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    output logic [REGSEL_W-1:0] o_adr,
    output logic                o_done
);

    logic [REGSEL_W-1:0] r_cnt;

    assign o_adr  = r_cnt;
    assign o_done = i_en && (r_cnt == REGSEL_W'(DEPTH - 1));

    // Wraps back to zero after the last word so the next sweep starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_done ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/npu_mem_arbiter.sv
// Two-requester arbiter for the NPU RAM: NPU priority, host anti-starvation, burst lock and zero-fill sweep.
module npu_mem_arbiter #(
    parameter int         DEPTH         = 512,
    parameter int         WIDTH         = 8,
    parameter int         MEMSEL_W      = 6,
    parameter int         REGSEL_W      = 9,
    parameter logic [2:0] MEM_ADDR      = npu_mem_pkg::MEM_ADDR_DEF,
    parameter int         HOST_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                h_req,
    input  logic                h_we,
    input  logic [REGSEL_W-1:0] h_addr,
    input  logic [WIDTH-1:0]    h_wdata,
    output logic                h_gnt,
    output logic                h_rvalid,
    output logic [WIDTH-1:0]    h_rdata,
    input  logic                n_req,
    input  logic                n_we,
    input  logic [REGSEL_W-1:0] n_addr,
    input  logic [WIDTH-1:0]    n_wdata,
    input  logic                n_lock,
    output logic                n_gnt,
    output logic                n_rvalid,
    output logic [WIDTH-1:0]    n_rdata,
    input  logic                clr_start,
    output logic                clr_busy,
    output logic [MEMSEL_W-1:0] ram_mem_adr,
    output logic [REGSEL_W-1:0] ram_reg_adr,
    output logic [WIDTH-1:0]    ram_din,
    output logic                ram_we,
    input  logic [WIDTH-1:0]    ram_dout
);
    import npu_mem_pkg::*;

    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 1);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [REGSEL_W-1:0] r_last_adr;
    logic                r_rd_pend;
    logic                r_rd_id;
    logic [WIDTH-1:0]    r_h_rdata;
    logic [WIDTH-1:0]    r_n_rdata;
    logic                w_arb;
    logic                w_starved;
    logic                w_h_sel;
    logic                w_n_sel;
    logic [REGSEL_W-1:0] w_clr_adr;
    logic                w_clr_done;

    npu_mem_clr_seq #(
        .DEPTH    (DEPTH),
        .REGSEL_W (REGSEL_W)
    ) u_clr_seq (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == CLEAR),
        .o_adr  (w_clr_adr),
        .o_done (w_clr_done)
    );

    // Grants are suppressed while reset is asserted so nothing reaches the RAM during reset.
    assign w_arb     = (r_state == ARB) && !rst;
    assign w_starved = h_req && (r_wait_cnt == WAIT_W'(HOST_MAX_WAIT));

    always_comb begin
        w_h_sel = 1'b0;
        w_n_sel = 1'b0;
        if (w_arb) begin
            if (w_starved) begin
                w_h_sel = 1'b1;
            end else if (n_req) begin
                w_n_sel = 1'b1;
            end else if (h_req && !n_lock) begin
                w_h_sel = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ARB:     if (clr_start)  w_next_state = CLEAR;
            CLEAR:   if (w_clr_done) w_next_state = ARB;
            default: w_next_state = ARB;
        endcase
    end

    // Idle cycles re-present the previous address so the macro sees no spurious activity.
    always_comb begin
        ram_we      = 1'b0;
        ram_din     = '0;
        ram_reg_adr = r_last_adr;
        if ((r_state == CLEAR) && !rst) begin
            ram_we      = 1'b1;
            ram_reg_adr = w_clr_adr;
        end else if (w_h_sel) begin
            ram_we      = h_we;
            ram_din     = h_wdata;
            ram_reg_adr = h_addr;
        end else if (w_n_sel) begin
            ram_we      = n_we;
            ram_din     = n_wdata;
            ram_reg_adr = n_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_wait_cnt <= '0;
            r_last_adr <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= REQ_HOST;
            r_h_rdata  <= '0;
            r_n_rdata  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_last_adr <= ram_reg_adr;
            r_rd_pend  <= (w_h_sel && !h_we) || (w_n_sel && !n_we);
            r_rd_id    <= w_n_sel ? REQ_NPU : REQ_HOST;
            if (h_rvalid) r_h_rdata <= ram_dout;
            if (n_rvalid) r_n_rdata <= ram_dout;
            if (r_state == ARB) begin
                if (!h_req || w_h_sel) begin
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != WAIT_W'(HOST_MAX_WAIT)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end
        end
    end

    assign h_gnt       = w_h_sel;
    assign n_gnt       = w_n_sel;
    assign h_rvalid    = r_rd_pend && (r_rd_id == REQ_HOST);
    assign n_rvalid    = r_rd_pend && (r_rd_id == REQ_NPU);
    assign h_rdata     = h_rvalid ? ram_dout : r_h_rdata;
    assign n_rdata     = n_rvalid ? ram_dout : r_n_rdata;
    assign clr_busy    = (r_state == CLEAR);
    assign ram_mem_adr = MEMSEL_W'(MEM_ADDR);

endmodule
